// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - mode encodings, raster defaults and bar colours for the pattern generator
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_BORDER = 2'd2,
    MODE_GRAD   = 2'd3
  } mode_e;

  // {r,g,b} full-scale masks, listed in bar index order
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_pixel_counter.sv
// rtl/vga_pixel_counter.sv - sync edge detects plus x/y/bar/frame counters (pipeline stage 1)
module vga_pixel_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        V_SYNC_IN,
  input  logic                        RGB_EN_IN,
  output logic                        en_q,
  output logic                        vs_q,
  output logic [$clog2(H_ACTIVE)-1:0] x,
  output logic [$clog2(V_ACTIVE)-1:0] y,
  output logic [2:0]                  bar_idx,
  output logic [7:0]                  frame_cnt,
  output logic                        frame_start
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int SW    = $clog2(BAR_W);

  localparam logic [XW-1:0] X_MAX   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(V_ACTIVE - 1);
  localparam logic [SW-1:0] SUB_MAX = SW'(BAR_W - 1);

  logic [SW-1:0] bar_sub;
  logic          line_start;
  logic          line_end;

  assign frame_start = vs_q & ~V_SYNC_IN;
  assign line_start  = RGB_EN_IN & ~en_q;
  assign line_end    = en_q & ~RGB_EN_IN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      en_q      <= 1'b0;
      vs_q      <= 1'b1;
      x         <= '0;
      y         <= '0;
      bar_sub   <= '0;
      bar_idx   <= '0;
      frame_cnt <= '0;
    end else begin
      en_q <= RGB_EN_IN;
      vs_q <= V_SYNC_IN;

      // frame start has priority over a coincident line end
      if (frame_start) begin
        y         <= '0;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (line_end && y != Y_MAX) begin
        y <= y + 1'b1;
      end

      // bar tracking freezes with x so overlong lines repeat the last column
      if (line_start) begin
        x       <= '0;
        bar_sub <= '0;
        bar_idx <= '0;
      end else if (RGB_EN_IN && x != X_MAX) begin
        x <= x + 1'b1;
        if (bar_sub == SUB_MAX) begin
          bar_sub <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_sub <= bar_sub + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - per-pixel test pattern generator with sync re-timing (2-cycle latency)
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int COLOR_W    = 4,
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               H_SYNC_IN,
  input  logic               V_SYNC_IN,
  input  logic               RGB_EN_IN,
  input  logic [1:0]         MODE,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               H_SYNC,
  output logic               V_SYNC
);

  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE - 1);

  logic               en_q;
  logic               vs_q;
  logic               hs_q;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [2:0]         bar_idx;
  logic [7:0]         frame_cnt;
  logic               frame_start;
  mode_e              active_mode;

  logic [2:0]         bar_mask;
  logic               check_on;
  logic               border_on;
  logic [7:0]         grad_sum;
  logic [COLOR_W-1:0] r_nxt;
  logic [COLOR_W-1:0] g_nxt;
  logic [COLOR_W-1:0] b_nxt;

  vga_pixel_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_counter (
    .CLK         (CLK),
    .RST         (RST),
    .V_SYNC_IN   (V_SYNC_IN),
    .RGB_EN_IN   (RGB_EN_IN),
    .en_q        (en_q),
    .vs_q        (vs_q),
    .x           (x),
    .y           (y),
    .bar_idx     (bar_idx),
    .frame_cnt   (frame_cnt),
    .frame_start (frame_start)
  );

  assign bar_mask  = bar_rgb(bar_idx);
  assign check_on  = x[CHECK_LOG2] ^ y[CHECK_LOG2];
  assign border_on = (x == '0) || (x == X_MAX) || (y == '0) || (y == Y_MAX);
  assign grad_sum  = x[7:0] + frame_cnt;

  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    if (en_q) begin
      unique case (active_mode)
        MODE_BARS: begin
          r_nxt = {COLOR_W{bar_mask[2]}};
          g_nxt = {COLOR_W{bar_mask[1]}};
          b_nxt = {COLOR_W{bar_mask[0]}};
        end
        MODE_CHECK: begin
          r_nxt = {COLOR_W{check_on}};
          g_nxt = {COLOR_W{check_on}};
          b_nxt = {COLOR_W{check_on}};
        end
        MODE_BORDER: begin
          r_nxt = {COLOR_W{border_on}};
          g_nxt = {COLOR_W{border_on}};
          b_nxt = {COLOR_W{border_on}};
        end
        MODE_GRAD: begin
          r_nxt = grad_sum[7 -: COLOR_W];
          g_nxt = y[7 -: COLOR_W];
        end
      endcase
    end
  end

  // stage 2: colour and both syncs leave together
  always_ff @(posedge CLK) begin
    if (RST) begin
      hs_q        <= 1'b1;
      H_SYNC      <= 1'b1;
      V_SYNC      <= 1'b1;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      active_mode <= MODE_BARS;
    end else begin
      hs_q   <= H_SYNC_IN;
      H_SYNC <= hs_q;
      V_SYNC <= vs_q;
      R      <= r_nxt;
      G      <= g_nxt;
      B      <= b_nxt;
      if (frame_start) begin
        active_mode <= mode_e'(MODE);
      end
    end
  end

endmodule
